// File: rtl/psram_wbuf.sv
// psram_wbuf: posted-write buffer in front of the psram controller.
// Writes ack after one cycle and drain in order; reads wait behind them.
module psram_wbuf #(
  parameter int depth     = 4,
  parameter int adr_width = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [adr_width-1:0] s_wb_adr_i,
  input  logic [31:0]          s_wb_dat_i,
  output logic [31:0]          s_wb_dat_o,
  input  logic [3:0]           s_wb_sel_i,
  input  logic                 s_wb_stb_i,
  input  logic                 s_wb_cyc_i,
  input  logic                 s_wb_we_i,
  output logic                 s_wb_ack_o,
  output logic [adr_width-1:0] m_wb_adr_o,
  output logic [31:0]          m_wb_dat_o,
  input  logic [31:0]          m_wb_dat_i,
  output logic [3:0]           m_wb_sel_o,
  output logic                 m_wb_stb_o,
  output logic                 m_wb_cyc_o,
  output logic                 m_wb_we_o,
  input  logic                 m_wb_ack_i,
  output logic                 wbuf_empty
);
  localparam int pw = $clog2(depth);
  localparam int cw = pw + 1;
  localparam logic [cw-1:0] full = cw'(depth);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    GAP
  } state_t;

  state_t state, state_n;

  logic [adr_width-1:0] fifo_adr [depth];
  logic [31:0]          fifo_dat [depth];
  logic [3:0]           fifo_sel [depth];

  logic [pw-1:0] wr_ptr, rd_ptr;
  logic [cw-1:0] count, count_n;
  logic          lock;
  logic          req, push, pop;
  logic          go_wr, go_rd, rd_done;

  // Lockout spans the ack cycle and the one after it.
  assign req  = s_wb_stb_i & s_wb_cyc_i & ~s_wb_ack_o & ~lock;
  assign push = req & s_wb_we_i & (count < full);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    go_wr   = 1'b0;
    go_rd   = 1'b0;
    rd_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          go_wr   = 1'b1;
          state_n = WR;
        end else if (req & ~s_wb_we_i) begin
          go_rd   = 1'b1;
          state_n = RD;
        end
      end
      WR: begin
        if (m_wb_ack_i) begin
          pop     = 1'b1;
          state_n = GAP;
        end
      end
      RD: begin
        if (m_wb_ack_i) begin
          rd_done = 1'b1;
          state_n = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    count_n = count;
    if (push & ~pop) count_n = count + cw'(1);
    else if (pop & ~push) count_n = count - cw'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_adr[wr_ptr] <= s_wb_adr_i;
      fifo_dat[wr_ptr] <= s_wb_dat_i;
      fifo_sel[wr_ptr] <= s_wb_sel_i;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lock       <= 1'b0;
      s_wb_ack_o <= 1'b0;
      s_wb_dat_o <= '0;
      m_wb_adr_o <= '0;
      m_wb_dat_o <= '0;
      m_wb_sel_o <= '0;
      m_wb_stb_o <= 1'b0;
      m_wb_cyc_o <= 1'b0;
      m_wb_we_o  <= 1'b0;
      wbuf_empty <= 1'b1;
    end else begin
      count      <= count_n;
      lock       <= s_wb_ack_o;
      s_wb_ack_o <= push | (rd_done & s_wb_cyc_i);
      wbuf_empty <= (count_n == '0) & (state_n == IDLE);
      if (push) wr_ptr <= wr_ptr + pw'(1);
      if (pop)  rd_ptr <= rd_ptr + pw'(1);
      if (rd_done) s_wb_dat_o <= m_wb_dat_i;
      if (go_wr) begin
        m_wb_adr_o <= fifo_adr[rd_ptr];
        m_wb_dat_o <= fifo_dat[rd_ptr];
        m_wb_sel_o <= fifo_sel[rd_ptr];
        m_wb_cyc_o <= 1'b1;
        m_wb_stb_o <= 1'b1;
        m_wb_we_o  <= 1'b1;
      end else if (go_rd) begin
        m_wb_adr_o <= s_wb_adr_i;
        m_wb_sel_o <= s_wb_sel_i;
        m_wb_cyc_o <= 1'b1;
        m_wb_stb_o <= 1'b1;
        m_wb_we_o  <= 1'b0;
      end else if (pop | rd_done) begin
        m_wb_cyc_o <= 1'b0;
        m_wb_stb_o <= 1'b0;
        m_wb_we_o  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_psram_wbuf.sv
// tb_psram_wbuf: directed bench for the posted-write buffer.
// A byte-lane memory model stands in for the psram controller.
module tb_psram_wbuf;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] s_wb_adr_i = '0;
  logic [31:0] s_wb_dat_i = '0;
  logic [31:0] s_wb_dat_o;
  logic [3:0]  s_wb_sel_i = '0;
  logic        s_wb_stb_i = 1'b0;
  logic        s_wb_cyc_i = 1'b0;
  logic        s_wb_we_i = 1'b0;
  logic        s_wb_ack_o;
  logic [31:0] m_wb_adr_o;
  logic [31:0] m_wb_dat_o;
  logic [31:0] m_wb_dat_i;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_stb_o;
  logic        m_wb_cyc_o;
  logic        m_wb_we_o;
  logic        m_wb_ack_i;
  logic        wbuf_empty;

  int total = 0;
  int bad = 0;

  psram_wbuf #(.depth(4), .adr_width(32)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i),
    .s_wb_dat_o(s_wb_dat_o), .s_wb_sel_i(s_wb_sel_i),
    .s_wb_stb_i(s_wb_stb_i), .s_wb_cyc_i(s_wb_cyc_i),
    .s_wb_we_i(s_wb_we_i), .s_wb_ack_o(s_wb_ack_o),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o),
    .m_wb_dat_i(m_wb_dat_i), .m_wb_sel_o(m_wb_sel_o),
    .m_wb_stb_o(m_wb_stb_o), .m_wb_cyc_o(m_wb_cyc_o),
    .m_wb_we_o(m_wb_we_o), .m_wb_ack_i(m_wb_ack_i),
    .wbuf_empty(wbuf_empty)
  );

  always #5 sys_clk = ~sys_clk;

  // psram controller model
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] mw_q[$];
  int lat = 0;
  int acks_left = -1;
  int wait_cnt = 0;
  int rd_wcount = -1;

  function automatic logic [31:0] rdword(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] b;
    b = a & ~32'h3;
    w = '0;
    for (int i = 0; i < 4; i++)
      if (mem.exists(b + i)) w[8*i +: 8] = mem[b + i];
    return w;
  endfunction

  initial begin
    m_wb_ack_i = 1'b0;
    m_wb_dat_i = 32'hdeadbeef;
    forever begin
      @(negedge sys_clk);
      m_wb_ack_i = 1'b0;
      m_wb_dat_i = 32'hdeadbeef;
      if (m_wb_stb_o && acks_left != 0) begin
        if (wait_cnt >= lat) begin
          m_wb_ack_i = 1'b1;
          wait_cnt = 0;
          if (acks_left > 0) acks_left--;
          if (m_wb_we_o) begin
            mw_q.push_back(m_wb_adr_o);
            for (int i = 0; i < 4; i++)
              if (m_wb_sel_o[i])
                mem[(m_wb_adr_o & ~32'h3) + i] = m_wb_dat_o[8*i +: 8];
          end else begin
            m_wb_dat_i = rdword(m_wb_adr_o);
            rd_wcount = mw_q.size();
          end
        end else begin
          wait_cnt++;
        end
      end else if (!m_wb_stb_o) begin
        wait_cnt = 0;
      end
    end
  end

  // edge-indexed monitor, sampled 1 ns after each rising edge
  int edge_no = 0;
  int last_mack_edge = -1;
  int last_ack_edge = -1;
  int last_launch_edge = -1;
  int ack_cnt = 0;
  int launch_cnt = 0;
  logic prev_stb = 1'b0;

  initial forever begin
    @(posedge sys_clk);
    edge_no++;
    if (m_wb_ack_i) last_mack_edge = edge_no;
    #1;
    if (s_wb_ack_o) begin
      last_ack_edge = edge_no;
      ack_cnt++;
    end
    if (m_wb_stb_o && !prev_stb) begin
      last_launch_edge = edge_no;
      launch_cnt++;
    end
    prev_stb = m_wb_stb_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int maxc,
                          output bit got, output int e0);
    @(negedge sys_clk);
    s_wb_adr_i = a;
    s_wb_dat_i = d;
    s_wb_sel_i = s;
    s_wb_we_i  = 1'b1;
    s_wb_stb_i = 1'b1;
    s_wb_cyc_i = 1'b1;
    e0 = edge_no + 1;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(posedge sys_clk);
      #1;
      got = s_wb_ack_o;
    end
  endtask

  task automatic wb_read(input logic [31:0] a, input int maxc,
                         output bit got, output int e0,
                         output logic [31:0] d);
    @(negedge sys_clk);
    s_wb_adr_i = a;
    s_wb_sel_i = 4'hf;
    s_wb_we_i  = 1'b0;
    s_wb_stb_i = 1'b1;
    s_wb_cyc_i = 1'b1;
    e0 = edge_no + 1;
    got = 1'b0;
    d = '0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(posedge sys_clk);
      #1;
      got = s_wb_ack_o;
      d = s_wb_dat_o;
    end
  endtask

  task automatic wait_ack(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(posedge sys_clk);
      #1;
      got = s_wb_ack_o;
    end
  endtask

  task automatic idle_bus();
    @(negedge sys_clk);
    s_wb_stb_i = 1'b0;
    s_wb_cyc_i = 1'b0;
    s_wb_we_i  = 1'b0;
  endtask

  task automatic wait_empty(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(posedge sys_clk);
      #1;
      ok = wbuf_empty & ~m_wb_cyc_o;
    end
  endtask

  initial begin
    bit got;
    bit ok;
    int e0;
    int ea[4];
    int a0;
    int m0;
    logic [31:0] d;
    logic [31:0] adrs[5];

    // reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_s_ack", s_wb_ack_o, 0);
    chk("rst_s_dat", s_wb_dat_o, 0);
    chk("rst_m_bus", {m_wb_adr_o, m_wb_dat_o}, 0);
    chk("rst_m_ctl", {m_wb_sel_o, m_wb_stb_o, m_wb_cyc_o, m_wb_we_o}, 0);
    chk("rst_empty", wbuf_empty, 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // single posted write, slow controller
    lat = 20;
    wb_write(32'hfff0, 32'h00010203, 4'hf, 10, got, e0);
    chk("t1_got_ack", got, 1);
    chk("t1_ack_edge", last_ack_edge, e0);
    chk("t1_empty_busy", wbuf_empty, 0);
    idle_bus();
    @(posedge sys_clk);
    #1;
    chk("t1_m_adr", m_wb_adr_o, 32'hfff0);
    chk("t1_m_dat", m_wb_dat_o, 32'h00010203);
    chk("t1_m_ctl", {m_wb_sel_o, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o}, 7'h7f);
    wait_empty(60, ok);
    chk("t1_drained", ok, 1);
    chk("t1_mem", rdword(32'hfff0), 32'h00010203);
    chk("t1_mw_cnt", mw_q.size(), 1);

    // five back-to-back writes into a stalled controller
    lat = 0;
    acks_left = 0;
    mw_q.delete();
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 5; i++) adrs[i] = 32'h1000 + 4 * i;
    for (int i = 0; i < 4; i++) begin
      wb_write(adrs[i], 32'ha0 + i, 4'hf, 10, got, e0);
      chk("t2_got_ack", got, 1);
      ea[i] = last_ack_edge;
    end
    for (int i = 1; i < 4; i++) chk("t2_ack_gap", ea[i] - ea[i-1], 3);
    wb_write(adrs[4], 32'ha4, 4'hf, 8, got, e0);
    chk("t2_full_noack", got, 0);
    acks_left = 1;
    wait_ack(10, got);
    chk("t2_full_ack", got, 1);
    chk("t2_push_after_pop", last_ack_edge - last_mack_edge, 1);
    acks_left = -1;
    idle_bus();
    wait_empty(100, ok);
    chk("t2_drained", ok, 1);
    chk("t2_mw_cnt", mw_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < mw_q.size()) chk("t2_order", mw_q[i], adrs[i]);

    // byte-lane writes then a read that must wait for them
    lat = 2;
    mw_q.delete();
    for (int i = 0; i < 4; i++) begin
      wb_write(32'hfff8 + i, (32'h08 + i) << (8 * i), 4'b0001 << i,
               20, got, e0);
      chk("t3_got_ack", got, 1);
    end
    wb_read(32'hfff8, 200, got, e0, d);
    chk("t3_rd_ack", got, 1);
    chk("t3_rd_data", d, 32'h0b0a0908);
    chk("t3_writes_first", rd_wcount, 4);
    idle_bus();
    wait_empty(20, ok);

    // stb held one cycle past the write ack
    a0 = ack_cnt;
    m0 = mw_q.size();
    wb_write(32'h2000, 32'h55aa55aa, 4'hf, 10, got, e0);
    @(negedge sys_clk);
    idle_bus();
    wait_empty(50, ok);
    chk("t4_drained", ok, 1);
    chk("t4_one_ack", ack_cnt - a0, 1);
    chk("t4_one_mw", mw_q.size() - m0, 1);

    // reset while a write is in flight
    acks_left = 0;
    m0 = mw_q.size();
    for (int i = 0; i < 3; i++)
      wb_write(32'h3000 + 4 * i, 32'h77 + i, 4'hf, 10, got, e0);
    idle_bus();
    @(negedge sys_clk);
    chk("t5_in_wr", m_wb_cyc_o & m_wb_we_o, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_s", {s_wb_ack_o, s_wb_dat_o}, 0);
    chk("t5_rst_m", {m_wb_adr_o, m_wb_dat_o, m_wb_sel_o,
                     m_wb_stb_o, m_wb_cyc_o, m_wb_we_o}, 0);
    chk("t5_rst_empty", wbuf_empty, 1);
    repeat (3) @(negedge sys_clk);
    acks_left = -1;
    a0 = launch_cnt;
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("t5_no_launch", launch_cnt - a0, 0);
    chk("t5_no_mw", mw_q.size() - m0, 0);
    chk("t5_empty", wbuf_empty, 1);

    // two reads with the buffer empty
    lat = 3;
    mem[32'h200] = 8'h44;
    mem[32'h201] = 8'h33;
    mem[32'h202] = 8'h22;
    mem[32'h203] = 8'h11;
    mem[32'h300] = 8'h0d;
    mem[32'h301] = 8'hf0;
    mem[32'h302] = 8'hfe;
    mem[32'h303] = 8'hca;
    wb_read(32'h200, 50, got, e0, d);
    chk("t6a_ack", got, 1);
    chk("t6a_launch", last_launch_edge, e0);
    chk("t6a_ack_edge", last_ack_edge, last_mack_edge);
    chk("t6a_data", d, 32'h11223344);
    idle_bus();
    repeat (3) @(negedge sys_clk);
    wb_read(32'h300, 50, got, e0, d);
    chk("t6b_ack", got, 1);
    chk("t6b_launch", last_launch_edge, e0);
    chk("t6b_ack_edge", last_ack_edge, last_mack_edge);
    chk("t6b_data", d, 32'hcafef00d);
    idle_bus();
    repeat (3) @(negedge sys_clk);
    chk("t6_dat_hold", s_wb_dat_o, 32'hcafef00d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
